// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file with busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int DefaultWidth = 32;
    localparam int DefaultDepth = 32;
    localparam int DefaultNread = 2;
    localparam int ZeroReg      = 0;

    // True for an address that names a real, writable register.
    function automatic logic addrLive(input int unsigned addr, input int unsigned depth);
        return (addr != 32'(ZeroReg)) && (addr < depth);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: data mux, busy lookup and optional forwarding.
// Forwarding path is present only when REGFILE_BYPASS_EN is defined.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = DefaultWidth,
    parameter int DEPTH = DefaultDepth,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] regs [DEPTH],
    input  logic [DEPTH-1:0] busy,
`ifdef REGFILE_BYPASS_EN
    input  logic             bypassValid,
    input  logic [AW-1:0]    bypassAddr,
    input  logic [WIDTH-1:0] bypassData,
`endif
    output logic [WIDTH-1:0] data,
    output logic             dataBusy
);

    logic addrOk;

    assign addrOk = addrLive(32'(addr), 32'(DEPTH));

    // Select register contents and busy state; zero/out-of-range addresses read idle zero.
    always_comb begin
        data     = {WIDTH{1'b0}};
        dataBusy = 1'b0;
        if (addrOk) begin
            data     = regs[addr];
            dataBusy = busy[addr];
        end else begin
            data     = {WIDTH{1'b0}};
            dataBusy = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        // bypassValid already implies a live, nonzero write address
        if (bypassValid && (bypassAddr == addr)) begin
            data     = bypassData;
            dataBusy = 1'b0;
        end else begin
            data     = data;
            dataBusy = dataBusy;
        end
`endif
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard and registered busy counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH = DefaultWidth,
    parameter int DEPTH = DefaultDepth,
    parameter int NREAD = DefaultNread,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREAD*AW-1:0]    ReadRegister,
    output logic [NREAD*WIDTH-1:0] ReadData,
    output logic [NREAD-1:0]       ReadBusy,
    input  logic [AW-1:0]          WriteRegister,
    input  logic [WIDTH-1:0]       WriteData,
    input  logic                   RegWrite,
    input  logic [AW-1:0]          IssueRegister,
    input  logic                   IssueValid,
    input  logic                   Flush,
    output logic [AW:0]            BusyCount
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic             writeHit;
    logic             issueHit;
    logic             countUp;
    logic             countDown;

    assign writeHit = RegWrite & ~Reset & addrLive(32'(WriteRegister), 32'(DEPTH));
    assign issueHit = IssueValid & ~Reset & addrLive(32'(IssueRegister), 32'(DEPTH));

    // Next busy vector: flush beats issue, and issue beats a same-register writeback.
    always_comb begin
        busyNext = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (Flush) begin
                busyNext[i] = 1'b0;
            end else if (issueHit && (IssueRegister == AW'(i))) begin
                busyNext[i] = 1'b1;
            end else if (writeHit && (WriteRegister == AW'(i))) begin
                busyNext[i] = 1'b0;
            end else begin
                busyNext[i] = busy[i];
            end
        end
    end

    // Incremental count deltas; a write to the register being re-issued nets to zero.
    always_comb begin
        countUp   = 1'b0;
        countDown = 1'b0;
        if (!Flush) begin
            countUp   = issueHit && !busy[IssueRegister];
            countDown = writeHit && busy[WriteRegister]
                        && !(issueHit && (IssueRegister == WriteRegister));
        end else begin
            countUp   = 1'b0;
            countDown = 1'b0;
        end
    end

    // Busy bits and busy counter.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            busy      <= {DEPTH{1'b0}};
            BusyCount <= {(AW+1){1'b0}};
        end else begin
            busy <= busyNext;
            if (Flush) begin
                BusyCount <= {(AW+1){1'b0}};
            end else begin
                case ({countUp, countDown})
                    2'b10:   BusyCount <= BusyCount + (AW+1)'(1);
                    2'b01:   BusyCount <= BusyCount - (AW+1)'(1);
                    default: BusyCount <= BusyCount;
                endcase
            end
        end
    end

    // Register storage; entry 0 is never written so it stays zero.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= {WIDTH{1'b0}};
            end
        end else if (writeHit) begin
            regs[WriteRegister] <= WriteData;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : gRead
        regfile_read_port #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) uReadPort (
            .addr        (ReadRegister[k*AW +: AW]),
            .regs        (regs),
            .busy        (busy),
`ifdef REGFILE_BYPASS_EN
            .bypassValid (writeHit),
            .bypassAddr  (WriteRegister),
            .bypassData  (WriteData),
`endif
            .data        (ReadData[k*WIDTH +: WIDTH]),
            .dataBusy    (ReadBusy[k])
        );
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard (DEPTH=24, NREAD=3) against a behavioural model.
module tb_regfile_scoreboard;

    localparam int W = 32;
    localparam int D = 24;
    localparam int N = 3;
    localparam int A = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*A-1:0] rdAddr;
    logic [N*W-1:0] rdData;
    logic [N-1:0]   rdBusy;
    logic [A-1:0]   wrAddr;
    logic [W-1:0]   wrData;
    logic           we;
    logic [A-1:0]   issAddr;
    logic           issValid;
    logic           flush;
    logic [A:0]     busyCount;

    regfile_scoreboard #(.WIDTH(W), .DEPTH(D), .NREAD(N)) dut (
        .Clk           (clk),
        .Reset         (rst),
        .ReadRegister  (rdAddr),
        .ReadData      (rdData),
        .ReadBusy      (rdBusy),
        .WriteRegister (wrAddr),
        .WriteData     (wrData),
        .RegWrite      (we),
        .IssueRegister (issAddr),
        .IssueValid    (issValid),
        .Flush         (flush),
        .BusyCount     (busyCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0 data, 1 busy, 2 count
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] mRegs [D];
    bit          mBusy [D];
    int          ra [N];

    // Monitor: compare everything queued for the current cycle at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sbq.size() > 0) begin
                exp_t        e;
                logic [31:0] act;
                e = sbq.pop_front();
                case (e.kind)
                    0:       act = rdData[e.port*W +: W];
                    1:       act = 32'(rdBusy[e.port]);
                    default: act = 32'(busyCount);
                endcase
                checks++;
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic setIn(input int a0, input int a1, input int a2, input bit w,
                         input int wa, input logic [31:0] wd,
                         input bit iv, input int ia, input bit fl);
        ra[0] = a0; ra[1] = a1; ra[2] = a2;
        rdAddr   = {5'(a2), 5'(a1), 5'(a0)};
        we       = w;
        wrAddr   = 5'(wa);
        wrData   = wd;
        issValid = iv;
        issAddr  = 5'(ia);
        flush    = fl;
    endtask

    function automatic bit live(input int a);
        return (a != 0) && (a < D);
    endfunction

    // Queue expectations for the present inputs, then advance one clock and update the model.
    task automatic step(input string tag);
        int cnt;
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                mRegs[i] = 32'h0;
                mBusy[i] = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            logic [31:0] ed;
            logic [31:0] eb;
            ed = live(ra[k]) ? mRegs[ra[k]] : 32'h0;
            eb = live(ra[k]) ? 32'(mBusy[ra[k]]) : 32'h0;
`ifdef REGFILE_BYPASS_EN
            if (we && !rst && live(int'(wrAddr)) && (int'(wrAddr) == ra[k])) begin
                ed = wrData;
                eb = 32'h0;
            end
`endif
            sbq.push_back('{$sformatf("%s.data%0d", tag, k), 0, k, ed});
            sbq.push_back('{$sformatf("%s.busy%0d", tag, k), 1, k, eb});
        end
        cnt = 0;
        for (int i = 0; i < D; i++) cnt += int'(mBusy[i]);
        sbq.push_back('{$sformatf("%s.count", tag), 2, 0, 32'(cnt)});
        @(posedge clk);
        if (!rst) begin
            if (we && live(int'(wrAddr))) begin
                mRegs[wrAddr] = wrData;
                mBusy[wrAddr] = 1'b0;
            end
            if (issValid && live(int'(issAddr))) mBusy[issAddr] = 1'b1;
            if (flush) for (int i = 0; i < D; i++) mBusy[i] = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        setIn(0, 0, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        setIn(3, 5, 7, 1'b1, 3, 32'hFFFF_FFFF, 1'b1, 5, 1'b0);
        step("in_reset");
        rst = 1'b0;

        setIn(3, 3, 3, 1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0); step("wr3");
        setIn(3, 3, 0, 1'b1, 0, 32'h0000_1234, 1'b0, 0, 1'b0); step("rd3_wr0");
        setIn(0, 3, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);         step("rd0");
        setIn(4, 9, 0, 1'b0, 0, 32'h0, 1'b1, 4, 1'b0);         step("iss4");
        setIn(4, 9, 0, 1'b0, 0, 32'h0, 1'b1, 9, 1'b0);         step("iss9");
        setIn(4, 9, 0, 1'b1, 4, 32'h44, 1'b0, 0, 1'b0);        step("wr4");
        setIn(4, 9, 0, 1'b0, 0, 32'h0, 1'b1, 9, 1'b0);         step("iss9_again");
        setIn(4, 9, 6, 1'b0, 0, 32'h0, 1'b1, 6, 1'b0);         step("iss6");
        setIn(6, 9, 0, 1'b1, 6, 32'h66, 1'b1, 6, 1'b0);        step("wr_iss6");
        setIn(6, 2, 9, 1'b0, 0, 32'h0, 1'b1, 2, 1'b1);         step("flush_iss2");
        setIn(6, 2, 9, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);         step("post_flush");
        setIn(8, 8, 0, 1'b1, 8, 32'hA5A5_A5A5, 1'b0, 0, 1'b0); step("wr8");
        setIn(8, 8, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);         step("rd8");
        setIn(30, 30, 30, 1'b1, 30, 32'hFFFF, 1'b1, 30, 1'b0); step("oor");
        setIn(30, 23, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);       step("oor_after");
        setIn(5, 7, 3, 1'b0, 0, 32'h0, 1'b1, 5, 1'b0);         step("iss5");
        setIn(5, 7, 3, 1'b0, 0, 32'h0, 1'b1, 7, 1'b0);         step("iss7");
        setIn(5, 7, 3, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);         step("busy57");
        setIn(5, 7, 3, 1'b1, 5, 32'hBAD, 1'b1, 9, 1'b1);
        #2 rst = 1'b1;
        step("mid_reset");
        rst = 1'b0;
        setIn(5, 7, 3, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);         step("after_reset");

        for (int n = 0; n < 400; n++) begin
            setIn($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                  ($urandom_range(0, 2) != 0), $urandom_range(0, 31), $urandom,
                  ($urandom_range(0, 2) != 0), $urandom_range(0, 31),
                  ($urandom_range(0, 29) == 0));
            rst = ($urandom_range(0, 59) == 0);
            step("rand");
            rst = 1'b0;
        end

        setIn(0, 0, 0, 1'b0, 0, 32'h0, 1'b0, 0, 1'b0);
        repeat (4) begin
            if (sbq.size() != 0) @(negedge clk);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
